// File: rtl/channel_packer_slot_reg.sv
// One assembly slot: a BIT_WIDTH register that loads on write enable.
// It has no reset because its contents only matter after a write.

module channel_packer_slot_reg #(
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [BIT_WIDTH-1:0] d,
    output logic [BIT_WIDTH-1:0] q
);

    logic [BIT_WIDTH-1:0] data_d;
    logic [BIT_WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (we) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/channel_packer.sv
// Serial-to-parallel packer: collects NUM_CHANNEL samples into one word and
// offers it downstream over valid/rdy, double-buffered for one sample per cycle.

module channel_packer #(
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned NUM_CHANNEL = 3,
    localparam int unsigned CNT_W      = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             soft_clr,
    input  logic                             in_valid,
    output logic                             in_rdy,
    input  logic [BIT_WIDTH-1:0]             in_data,
    input  logic                             out_rdy,
    output logic                             out_valid,
    output logic [NUM_CHANNEL*BIT_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]                 chan_idx
);

    localparam int unsigned OUT_W = NUM_CHANNEL * BIT_WIDTH;
    localparam int unsigned ASM_N = (NUM_CHANNEL > 1) ? NUM_CHANNEL - 1 : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHANNEL - 1);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    logic [0:0]           state_d;
    logic [0:0]           state_q;
    logic [CNT_W-1:0]     chan_idx_d;
    logic [CNT_W-1:0]     chan_idx_q;
    logic [OUT_W-1:0]     out_data_d;
    logic [OUT_W-1:0]     out_data_q;
    logic [OUT_W-1:0]     new_word;
    logic                 in_fire;
    logic                 out_fire;
    logic                 last;
    logic [BIT_WIDTH-1:0] slot_q [ASM_N];

    // The last slot can only be taken when the output register is free or draining.
    assign in_rdy = (chan_idx_q != LAST_IDX) || (state_q == FILL) || out_rdy;

    generate
        if (NUM_CHANNEL > 1) begin : g_asm
            for (genvar i = 0; i < int'(NUM_CHANNEL) - 1; i++) begin : g_slot
                channel_packer_slot_reg #(
                    .BIT_WIDTH (BIT_WIDTH)
                ) u_slot (
                    .clk (clk),
                    .we  (in_fire && (chan_idx_q == CNT_W'(i))),
                    .d   (in_data),
                    .q   (slot_q[i])
                );
            end
        end else begin : g_no_asm
            assign slot_q[0] = '0;
        end
    endgenerate

    // soft_clr drops the sample on the assembly side but leaves the output word alone.
    always_comb begin
        in_fire    = in_valid && in_rdy && !soft_clr;
        out_fire   = (state_q == FULL) && out_rdy;
        last       = (chan_idx_q == LAST_IDX);
        state_d    = state_q;
        chan_idx_d = chan_idx_q;
        out_data_d = out_data_q;

        new_word = '0;
        new_word[OUT_W-1 -: BIT_WIDTH] = in_data;
        for (int i = 0; i < int'(NUM_CHANNEL) - 1; i++) begin
            new_word[i*BIT_WIDTH +: BIT_WIDTH] = slot_q[i];
        end

        if (soft_clr) begin
            chan_idx_d = '0;
        end else if (in_fire) begin
            chan_idx_d = last ? '0 : chan_idx_q + CNT_W'(1);
        end

        if (in_fire && last) begin
            state_d    = FULL;
            out_data_d = new_word;
        end else if (out_fire) begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            chan_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            chan_idx_q <= chan_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign chan_idx  = chan_idx_q;

endmodule

// File: tb/tb_channel_packer.sv
// Directed bench for channel_packer (N=3 and N=1 instances) with a queue of
// expected output words checked whenever a word is presented.

module tb_channel_packer;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_clr, a_iv, a_ir, a_or, a_ov;
    logic [7:0]  a_id;
    logic [23:0] a_od;
    logic [1:0]  a_idx;

    logic        b_clr, b_iv, b_ir, b_or, b_ov;
    logic [7:0]  b_id;
    logic [7:0]  b_od;
    logic [0:0]  b_idx;

    int tests = 0;
    int fails = 0;
    logic [23:0] a_q[$];
    logic [7:0]  b_q[$];

    always #5 clk = ~clk;

    channel_packer #(.BIT_WIDTH(8), .NUM_CHANNEL(3)) dut_a (
        .clk(clk), .rst(rst), .soft_clr(a_clr), .in_valid(a_iv), .in_rdy(a_ir),
        .in_data(a_id), .out_rdy(a_or), .out_valid(a_ov), .out_data(a_od), .chan_idx(a_idx)
    );

    channel_packer #(.BIT_WIDTH(8), .NUM_CHANNEL(1)) dut_b (
        .clk(clk), .rst(rst), .soft_clr(b_clr), .in_valid(b_iv), .in_rdy(b_ir),
        .in_data(b_id), .out_rdy(b_or), .out_valid(b_ov), .out_data(b_od), .chan_idx(b_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the N=3 instance; expected handshake flags are given per step.
    task automatic sa(input logic v, input logic [7:0] d, input logic ordy, input logic clr,
                      input logic e_rdy, input logic e_ov, input logic [1:0] e_idx);
        logic fire;
        @(negedge clk);
        a_iv = v; a_id = d; a_or = ordy; a_clr = clr;
        #1;
        chk("a_in_rdy", 32'(a_ir), 32'(e_rdy));
        chk("a_out_valid", 32'(a_ov), 32'(e_ov));
        chk("a_chan_idx", 32'(a_idx), 32'(e_idx));
        fire = a_ov && ordy;
        if (a_ov === 1'b1) begin
            if (a_q.size() == 0) chk("a_unexpected_word", 32'(a_od), 32'hFFFF_FFFF);
            else chk("a_out_data", 32'(a_od), 32'(a_q[0]));
        end
        @(posedge clk);
        if (fire && a_q.size() != 0) void'(a_q.pop_front());
    endtask

    task automatic sb(input logic v, input logic [7:0] d, input logic ordy,
                      input logic e_rdy, input logic e_ov);
        logic fire;
        @(negedge clk);
        b_iv = v; b_id = d; b_or = ordy; b_clr = 1'b0;
        #1;
        chk("b_in_rdy", 32'(b_ir), 32'(e_rdy));
        chk("b_out_valid", 32'(b_ov), 32'(e_ov));
        chk("b_chan_idx", 32'(b_idx), 32'h0);
        fire = b_ov && ordy;
        if (b_ov === 1'b1) begin
            if (b_q.size() == 0) chk("b_unexpected_word", 32'(b_od), 32'hFFFF_FFFF);
            else chk("b_out_data", 32'(b_od), 32'(b_q[0]));
        end
        @(posedge clk);
        if (fire && b_q.size() != 0) void'(b_q.pop_front());
    endtask

    initial begin
        rst = 1'b1;
        a_clr = 0; a_iv = 0; a_id = 0; a_or = 0;
        b_clr = 0; b_iv = 0; b_id = 0; b_or = 0;
        #12;
        chk("rst_in_rdy", 32'(a_ir), 32'h1);
        chk("rst_out_valid", 32'(a_ov), 32'h0);
        chk("rst_chan_idx", 32'(a_idx), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // basic packing
        sa(1, 8'h11, 1, 0, 1, 0, 0);
        sa(1, 8'h22, 1, 0, 1, 0, 1);
        a_q.push_back(24'h332211);
        sa(1, 8'h33, 1, 0, 1, 0, 2);
        sa(0, 8'h00, 1, 0, 1, 1, 0);
        sa(0, 8'h00, 1, 0, 1, 0, 0);

        // streaming 0x01..0x09
        sa(1, 8'h01, 1, 0, 1, 0, 0);
        sa(1, 8'h02, 1, 0, 1, 0, 1);
        a_q.push_back(24'h030201);
        sa(1, 8'h03, 1, 0, 1, 0, 2);
        sa(1, 8'h04, 1, 0, 1, 1, 0);
        sa(1, 8'h05, 1, 0, 1, 0, 1);
        a_q.push_back(24'h060504);
        sa(1, 8'h06, 1, 0, 1, 0, 2);
        sa(1, 8'h07, 1, 0, 1, 1, 0);
        sa(1, 8'h08, 1, 0, 1, 0, 1);
        a_q.push_back(24'h090807);
        sa(1, 8'h09, 1, 0, 1, 0, 2);
        sa(0, 8'h00, 1, 0, 1, 1, 0);
        sa(0, 8'h00, 1, 0, 1, 0, 0);

        // back-pressure
        sa(1, 8'h11, 0, 0, 1, 0, 0);
        sa(1, 8'h22, 0, 0, 1, 0, 1);
        a_q.push_back(24'h332211);
        sa(1, 8'h33, 0, 0, 1, 0, 2);
        sa(1, 8'h44, 0, 0, 1, 1, 0);
        sa(1, 8'h55, 0, 0, 1, 1, 1);
        sa(1, 8'h66, 0, 0, 0, 1, 2);
        sa(1, 8'h66, 0, 0, 0, 1, 2);
        a_q.push_back(24'h665544);
        sa(1, 8'h66, 1, 0, 1, 1, 2);
        sa(0, 8'h00, 0, 0, 1, 1, 0);
        sa(0, 8'h00, 1, 0, 1, 1, 0);
        sa(0, 8'h00, 1, 0, 1, 0, 0);

        // soft_clr drops the partial word and the sample in the same cycle
        sa(1, 8'hAA, 1, 0, 1, 0, 0);
        sa(1, 8'hBB, 1, 0, 1, 0, 1);
        sa(1, 8'hCC, 1, 1, 1, 0, 2);
        sa(1, 8'h01, 1, 0, 1, 0, 0);
        sa(1, 8'h02, 1, 0, 1, 0, 1);
        a_q.push_back(24'h030201);
        sa(1, 8'h03, 1, 0, 1, 0, 2);
        sa(0, 8'h00, 1, 0, 1, 1, 0);
        sa(0, 8'h00, 1, 0, 1, 0, 0);

        // soft_clr while a word is pending keeps that word
        sa(1, 8'h01, 0, 0, 1, 0, 0);
        sa(1, 8'h02, 0, 0, 1, 0, 1);
        a_q.push_back(24'h030201);
        sa(1, 8'h03, 0, 0, 1, 0, 2);
        sa(1, 8'h44, 0, 0, 1, 1, 0);
        sa(1, 8'h55, 0, 1, 1, 1, 1);
        sa(0, 8'h00, 0, 0, 1, 1, 0);
        sa(0, 8'h00, 1, 0, 1, 1, 0);
        sa(0, 8'h00, 1, 0, 1, 0, 0);

        // asynchronous reset mid-word with a word pending
        sa(1, 8'h11, 0, 0, 1, 0, 0);
        sa(1, 8'h22, 0, 0, 1, 0, 1);
        a_q.push_back(24'h332211);
        sa(1, 8'h33, 0, 0, 1, 0, 2);
        sa(1, 8'h44, 0, 0, 1, 1, 0);
        @(negedge clk);
        a_iv = 1'b0;
        chk("pre_rst_out_valid", 32'(a_ov), 32'h1);
        chk("pre_rst_chan_idx", 32'(a_idx), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(a_ov), 32'h0);
        chk("async_rst_chan_idx", 32'(a_idx), 32'h0);
        a_q.delete();
        @(negedge clk);
        rst = 1'b0;
        sa(1, 8'h01, 1, 0, 1, 0, 0);
        sa(1, 8'h02, 1, 0, 1, 0, 1);
        a_q.push_back(24'h030201);
        sa(1, 8'h03, 1, 0, 1, 0, 2);
        sa(0, 8'h00, 1, 0, 1, 1, 0);
        sa(0, 8'h00, 1, 0, 1, 0, 0);
        sa(0, 8'h00, 1, 0, 1, 0, 0);

        // NUM_CHANNEL = 1
        b_q.push_back(8'h5A);
        sb(1, 8'h5A, 0, 1, 0);
        b_q.push_back(8'hA5);
        sb(1, 8'hA5, 1, 1, 1);
        sb(0, 8'h00, 1, 1, 1);
        sb(0, 8'h00, 1, 1, 0);
        b_q.push_back(8'h3C);
        sb(1, 8'h3C, 0, 1, 0);
        sb(1, 8'h77, 0, 0, 1);
        sb(0, 8'h00, 1, 1, 1);
        sb(0, 8'h00, 1, 1, 0);

        chk("a_queue_drained", 32'(a_q.size()), 32'h0);
        chk("b_queue_drained", 32'(b_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/channel_packer.md
Name: channel_packer

Overview:
- Width converter on the writer side of the inter-layer valid/rdy link.
- Accepts a serial stream of single-channel samples, BIT_WIDTH each, and assembles NUM_CHANNEL consecutive samples into one wide word.
- Presents each wide word downstream with the same valid/rdy handshake used between layers, so it can drive a channel buffer input directly.
- Double-buffered (assembly register plus output register), so it sustains one sample per cycle under no back-pressure.

Parameters:
- BIT_WIDTH, 8, bits per channel sample.
- NUM_CHANNEL, 3, samples per output word; legal values are 1 or greater.
- CNT_W, max(1, clog2(NUM_CHANNEL)), channel counter width; localparam, not overridable.

Ports:
- clk  input  1  system clock.
- rst  input  1  system reset, asynchronous, active-high.
- soft_clr  input  1  synchronous clear; discards any partial word.
- in_valid  input  1  upstream sample valid.
- in_rdy  output  1  upstream ready.
- in_data  input  BIT_WIDTH  channel sample.
- out_rdy  input  1  downstream ready.
- out_valid  output  1  downstream word valid.
- out_data  output  NUM_CHANNEL*BIT_WIDTH  packed word; channel 0 sits in bits [BIT_WIDTH-1:0].
- chan_idx  output  CNT_W  slot the next accepted sample will fill.

Behaviour:
- Transfer rules:
  - Input transfer occurs on a clk edge where in_valid && in_rdy.
  - Output transfer occurs on a clk edge where out_valid && out_rdy.
  - No combinational path from in_valid or in_data to out_valid or out_data.
- Reset values (rst asserted, asynchronously): chan_idx=0, out_valid=0, state=FILL. in_rdy reads 1 after reset.
- Data registers:
  - Assembly and output data registers have no reset.
  - out_data is don't-care while out_valid=0.
- State machine, one bit:
  - FILL: output register empty; out_valid=0.
  - FULL: output register holds a word; out_valid=1.
- Ready logic:
  - in_rdy = (chan_idx != NUM_CHANNEL-1) || state==FILL || out_rdy.
  - The out_rdy-to-in_rdy combinational path is intended; it gives full throughput.
- Non-last input transfer (chan_idx < NUM_CHANNEL-1):
  - Write in_data into assembly slot chan_idx.
  - chan_idx increments by 1.
- Last-slot input transfer (chan_idx == NUM_CHANNEL-1):
  - Output register loads {in_data, assembly slots NUM_CHANNEL-2..0}.
  - chan_idx wraps to 0.
  - State goes to FULL; out_valid=1 on the next cycle. Latency is 1 cycle from the last-sample edge.
- Output transfer with no simultaneous last-slot input: state returns to FILL and out_valid falls next cycle.
- Simultaneous output transfer and last-slot input: output register reloads with the new word and stays FULL. Back-to-back words have no bubble.
- Back-pressure:
  - In FULL with out_rdy=0, slots 0..NUM_CHANNEL-2 can still be filled.
  - in_rdy drops only at the last slot.
  - out_data and out_valid are held stable until the output transfer.
- soft_clr (synchronous, highest priority on the assembly side):
  - chan_idx goes to 0 and any input sample in that cycle is dropped.
  - The output register and its state are unaffected; a word pending in FULL is still delivered.
  - in_rdy is unaffected by soft_clr.
- NUM_CHANNEL=1: every accepted sample goes straight to the output register; chan_idx is constant 0.
- Reset mid-word or mid-hold: partial word and pending output word are lost; no spurious out_valid after reset release.
- Throughput: with in_valid=1 and out_rdy=1 continuously, one word every NUM_CHANNEL cycles.

Decomposition:
- No shared package. The CNT_W clog2 helper goes in the common function include if one exists; otherwise it is a localparam expression.
- One sub-module is natural: channel_packer_slot_reg, a BIT_WIDTH write-enabled register with no reset.
  - Instantiate NUM_CHANNEL-1 copies in a generate loop for the assembly slots.
- The FSM, counter and output register stay in the top module, about 150 lines in total.

Test Plan:
- Basic packing. W=8, N=3, out_rdy=1; inputs 0x11, 0x22, 0x33 on consecutive cycles -> out_valid=1 one cycle after the 0x33 edge, out_data=0x332211, out_valid=0 the following cycle.
- Streaming. in_valid=1 every cycle with samples 0x01..0x09, out_rdy=1 -> in_rdy never drops; words 0x030201, 0x060504, 0x090807 appear every 3 cycles with no gaps.
- Back-pressure. out_rdy=0, samples 0x11..0x66 offered -> first word 0x332211 held; 0x44 and 0x55 accepted; in_rdy=0 with chan_idx=2. Raise out_rdy -> 0x332211 transfers on the same edge 0x66 is accepted; 0x665544 follows with out_valid held continuously.
- soft_clr. Accept 0xAA, 0xBB, then pulse soft_clr together with in_valid and 0xCC -> chan_idx=0 and 0xCC dropped. Then 0x01, 0x02, 0x03 -> out_data=0x030201. A word pending in FULL during the pulse is still delivered intact.
- Reset. Assert rst asynchronously while chan_idx=1 and out_valid=1 -> out_valid=0 and chan_idx=0 immediately. After release, 3 new samples produce exactly one correct word.
- N=1. Inputs 0x5A, 0xA5 with out_rdy toggling 0,1,1 -> each sample becomes one output word in order; in_rdy=0 only while FULL and out_rdy=0.
